// File: rtl/tartaruga_pkg.sv
// Shared core types: ROB/store-buffer indices and the writeback request bundle.
// Exports ROB_SIZE, rob_idx_t, bus32_t, store_buffer_idx_t, wb_req_t, WB_NUM_REQ, rob_age().
package tartaruga_pkg;

    localparam int ROB_SIZE          = 8;
    localparam int ROB_IDX_W         = $clog2(ROB_SIZE);
    localparam int STORE_BUFFER_SIZE = 4;
    localparam int SB_IDX_W          = $clog2(STORE_BUFFER_SIZE);

    typedef logic [ROB_IDX_W-1:0] rob_idx_t;
    typedef logic [31:0]          bus32_t;
    typedef logic [SB_IDX_W-1:0]  store_buffer_idx_t;

    typedef struct packed {
        rob_idx_t          rob_idx;
        bus32_t            result;
        bus32_t            new_pc;
        logic              branch_taken;
        store_buffer_idx_t store_buffer_idx;
        int                kanata_id;
    } wb_req_t;

    localparam int WB_NUM_REQ = 3;

    // Distance of a ROB entry from the head; wraps at ROB_SIZE.
    function automatic rob_idx_t rob_age(rob_idx_t idx, rob_idx_t head);
        return idx - head;
    endfunction

endpackage

// File: rtl/wb_req_fifo.sv
// Per-requester result FIFO with push/pop/flush and async active-low reset.
// Ports: clk_i, rstn_i, flush_i, push_i/data_i, pop_i/data_o, full_o, empty_o, count_o.
module wb_req_fifo
    import tartaruga_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  wb_req_t                    data_i,
    input  logic                       pop_i,
    output wb_req_t                    data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    wb_req_t         mem_q [DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PW-1:0] ptr_next(logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rptr_q];

    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = ptr_next(wptr_q);
            if (do_pop)  rptr_d = ptr_next(rptr_q);
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: a slot is only read after it was written.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Oldest-first arbiter of functional-unit results onto the ROB writeback port.
// Ports: clk_i, rstn_i, flush_i, rob_head_i, req_valid_i/req_data_i/req_ready_o,
// wb_* registered writeback outputs, contention_cnt_o (cycles with >=2 busy FIFOs).
module wb_arbiter
    import tartaruga_pkg::*;
#(
    parameter int NUM_REQ     = WB_NUM_REQ,
    parameter int QUEUE_DEPTH = 2,
    parameter int CNT_W       = 32
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       flush_i,
    input  rob_idx_t                   rob_head_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  wb_req_t [NUM_REQ-1:0]      req_data_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic                       wb_valid_o,
    output rob_idx_t                   wb_rob_idx_o,
    output bus32_t                     wb_result_o,
    output bus32_t                     wb_new_pc_o,
    output logic                       wb_branch_taken_o,
    output store_buffer_idx_t          wb_store_buffer_idx_o,
    output int                         wb_kanata_id_o,
    output logic [CNT_W-1:0]           contention_cnt_o
);

    localparam int WIN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int QCW   = $clog2(QUEUE_DEPTH + 1);

    wb_req_t            head_data [NUM_REQ];
    rob_idx_t           age       [NUM_REQ];
    logic [QCW-1:0]     q_count   [NUM_REQ];
    logic [NUM_REQ-1:0] q_full;
    logic [NUM_REQ-1:0] q_empty;
    logic [NUM_REQ-1:0] push;
    logic [NUM_REQ-1:0] pop;

    logic               win_found;
    logic [WIN_W-1:0]   win_idx;
    rob_idx_t           win_age;
    logic               multi_busy;

    logic               wb_valid_q, wb_valid_d;
    wb_req_t            wb_data_q, wb_data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        assign req_ready_o[g] = ~q_full[g];
        assign push[g] = req_valid_i[g] & ~q_full[g] & ~flush_i;
        assign pop[g]  = win_found & (win_idx == WIN_W'(g)) & ~flush_i;
        assign age[g]  = rob_age(head_data[g].rob_idx, rob_head_i);

        wb_req_fifo #(
            .DEPTH   (QUEUE_DEPTH)
        ) u_fifo (
            .clk_i   (clk_i),
            .rstn_i  (rstn_i),
            .flush_i (flush_i),
            .push_i  (push[g]),
            .data_i  (req_data_i[g]),
            .pop_i   (pop[g]),
            .data_o  (head_data[g]),
            .full_o  (q_full[g]),
            .empty_o (q_empty[g]),
            .count_o (q_count[g])
        );
    end

    // Strict less-than while scanning upward keeps the lowest index on ties.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_age   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!q_empty[k] && (!win_found || age[k] < win_age)) begin
                win_found = 1'b1;
                win_idx   = WIN_W'(k);
                win_age   = age[k];
            end
        end
    end

    always_comb begin
        logic seen;
        seen       = 1'b0;
        multi_busy = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (q_count[k] != '0) begin
                if (seen) multi_busy = 1'b1;
                seen = 1'b1;
            end
        end
    end

    // Data holds when nothing is granted; flush kills the grant.
    always_comb begin
        wb_valid_d = win_found & ~flush_i;
        wb_data_d  = wb_data_q;
        if (wb_valid_d) wb_data_d = head_data[win_idx];
    end

    always_comb begin
        cnt_d = cnt_q;
        if (multi_busy && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            cnt_q      <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            cnt_q      <= cnt_d;
        end
    end

    assign wb_valid_o            = wb_valid_q;
    assign wb_rob_idx_o          = wb_data_q.rob_idx;
    assign wb_result_o           = wb_data_q.result;
    assign wb_new_pc_o           = wb_data_q.new_pc;
    assign wb_branch_taken_o     = wb_data_q.branch_taken;
    assign wb_store_buffer_idx_o = wb_data_q.store_buffer_idx;
    assign wb_kanata_id_o        = wb_data_q.kanata_id;
    assign contention_cnt_o      = cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_wb_arbiter;
    import tartaruga_pkg::*;

    logic              clk = 1'b0;
    logic              rstn;
    logic              flush;
    rob_idx_t          head;
    logic [2:0]        vld;
    wb_req_t [2:0]     dat;
    logic [2:0]        req_ready_o;
    logic              wb_valid_o;
    rob_idx_t          wb_rob_idx_o;
    bus32_t            wb_result_o;
    bus32_t            wb_new_pc_o;
    logic              wb_branch_taken_o;
    store_buffer_idx_t wb_store_buffer_idx_o;
    int                wb_kanata_id_o;
    logic [31:0]       contention_cnt_o;

    always #5 clk = ~clk;

    wb_arbiter #(
        .NUM_REQ               (3),
        .QUEUE_DEPTH           (2),
        .CNT_W                 (32)
    ) dut (
        .clk_i                 (clk),
        .rstn_i                (rstn),
        .flush_i               (flush),
        .rob_head_i            (head),
        .req_valid_i           (vld),
        .req_data_i            (dat),
        .req_ready_o           (req_ready_o),
        .wb_valid_o            (wb_valid_o),
        .wb_rob_idx_o          (wb_rob_idx_o),
        .wb_result_o           (wb_result_o),
        .wb_new_pc_o           (wb_new_pc_o),
        .wb_branch_taken_o     (wb_branch_taken_o),
        .wb_store_buffer_idx_o (wb_store_buffer_idx_o),
        .wb_kanata_id_o        (wb_kanata_id_o),
        .contention_cnt_o      (contention_cnt_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per requester, the registered output, the counter.
    wb_req_t     mq [3][$];
    logic        m_valid;
    wb_req_t     m_out;
    logic [31:0] m_cnt;
    logic [2:0]  acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic wb_req_t rand_req();
        wb_req_t r;
        r.rob_idx          = rob_idx_t'($urandom_range(0, ROB_SIZE - 1));
        r.result           = $urandom;
        r.new_pc           = $urandom;
        r.branch_taken     = 1'($urandom_range(0, 1));
        r.store_buffer_idx = store_buffer_idx_t'($urandom);
        r.kanata_id        = int'($urandom);
        return r;
    endfunction

    function automatic logic [2:0] model_ready();
        logic [2:0] r;
        for (int k = 0; k < 3; k++) r[k] = (mq[k].size() < 2);
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) mq[k].delete();
        m_valid = 1'b0;
        m_out   = '0;
        m_cnt   = '0;
    endtask

    task automatic model_step();
        int busy;
        int best;
        int bage;
        int a;
        busy = 0;
        best = -1;
        bage = ROB_SIZE + 1;
        for (int k = 0; k < 3; k++) begin
            if (mq[k].size() > 0) begin
                busy++;
                a = (int'(mq[k][0].rob_idx) - int'(head) + ROB_SIZE) % ROB_SIZE;
                if (a < bage) begin
                    bage = a;
                    best = k;
                end
            end
        end
        if (busy >= 2 && m_cnt != 32'hFFFF_FFFF) m_cnt++;
        if (flush) begin
            m_valid = 1'b0;
            for (int k = 0; k < 3; k++) mq[k].delete();
        end else begin
            if (best >= 0) begin
                m_valid = 1'b1;
                m_out   = mq[best].pop_front();
            end else begin
                m_valid = 1'b0;
            end
            for (int k = 0; k < 3; k++) if (acc[k]) mq[k].push_back(dat[k]);
        end
    endtask

    task automatic check_outputs();
        chk("wb_valid", wb_valid_o, m_valid);
        chk("wb_rob_idx", wb_rob_idx_o, m_out.rob_idx);
        chk("wb_result", wb_result_o, m_out.result);
        chk("wb_new_pc", wb_new_pc_o, m_out.new_pc);
        chk("wb_branch_taken", wb_branch_taken_o, m_out.branch_taken);
        chk("wb_sb_idx", wb_store_buffer_idx_o, m_out.store_buffer_idx);
        chk("wb_kanata_id", wb_kanata_id_o, m_out.kanata_id);
        chk("contention_cnt", contention_cnt_o, m_cnt);
        chk("req_ready", req_ready_o, model_ready());
    endtask

    task automatic cycle();
        logic [2:0] rdy;
        rdy = model_ready();
        chk("req_ready_pre", req_ready_o, rdy);
        acc = vld & rdy & {3{~flush}};
        @(posedge clk);
        #1;
        model_step();
        check_outputs();
    endtask

    initial begin
        rstn  = 1'b0;
        flush = 1'b0;
        head  = '0;
        vld   = '0;
        dat   = '0;
        acc   = '0;
        model_reset();

        // Reset state and idle.
        #12;
        check_outputs();
        rstn = 1'b1;
        repeat (4) cycle();
        chk("idle_valid", wb_valid_o, 1'b0);
        chk("idle_ready", req_ready_o, 3'b111);

        // Single request: accept at E, visible only after E+1.
        dat[0] = rand_req();
        dat[0].rob_idx = 3'd3;
        dat[0].result  = 32'hDEAD;
        vld = 3'b001;
        cycle();
        chk("t2_accept", acc, 3'b001);
        chk("t2_no_bypass", wb_valid_o, 1'b0);
        vld = '0;
        cycle();
        chk("t2_valid", wb_valid_o, 1'b1);
        chk("t2_idx", wb_rob_idx_o, 3'd3);
        chk("t2_result", wb_result_o, 32'hDEAD);
        cycle();
        chk("t2_one_cycle", wb_valid_o, 1'b0);

        // Age ordering with wrap-around.
        head = 3'd6;
        dat[0] = rand_req();
        dat[1] = rand_req();
        dat[2] = rand_req();
        dat[0].rob_idx = 3'd1;
        dat[1].rob_idx = 3'd7;
        dat[2].rob_idx = 3'd6;
        vld = 3'b111;
        cycle();
        vld = '0;
        cycle();
        chk("t3_g0_valid", wb_valid_o, 1'b1);
        chk("t3_g0_idx", wb_rob_idx_o, 3'd6);
        cycle();
        chk("t3_g1_idx", wb_rob_idx_o, 3'd7);
        cycle();
        chk("t3_g2_idx", wb_rob_idx_o, 3'd1);
        chk("t3_cnt", contention_cnt_o, 32'd2);
        cycle();

        // FIFO1 fills while requester 0 keeps winning on age.
        head = 3'd0;
        dat[0] = rand_req();
        dat[0].rob_idx = 3'd0;
        dat[1] = rand_req();
        dat[1].rob_idx = 3'd5;
        vld = 3'b011;
        begin
            int n1;
            n1 = 0;
            for (int i = 0; i < 6; i++) begin
                cycle();
                if (acc[0]) begin
                    dat[0] = rand_req();
                    dat[0].rob_idx = 3'd0;
                end
                if (acc[1]) begin
                    n1++;
                    dat[1] = rand_req();
                    dat[1].rob_idx = 3'd5;
                end
            end
            chk("t4_n1_accepted", n1, 2);
            chk("t4_full", req_ready_o[1], 1'b0);
            vld[0] = 1'b0;
            for (int i = 0; i < 12 && vld[1]; i++) begin
                cycle();
                if (acc[1]) vld[1] = 1'b0;
            end
            chk("t4_third_accepted", vld[1], 1'b0);
        end
        repeat (4) cycle();

        // Flush with four entries buffered and a grant in the output register.
        dat[0] = rand_req();
        dat[1] = rand_req();
        dat[2] = rand_req();
        vld = 3'b111;
        cycle();
        dat[0] = rand_req();
        dat[1] = rand_req();
        vld = 3'b011;
        cycle();
        chk("t5_pre_valid", wb_valid_o, 1'b1);
        chk("t5_buffered", mq[0].size() + mq[1].size() + mq[2].size(), 4);
        dat[0] = rand_req();
        vld   = 3'b001;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        vld   = '0;
        chk("t5_flush_valid", wb_valid_o, 1'b0);
        chk("t5_flush_ready", req_ready_o, 3'b111);
        repeat (4) cycle();

        // Random traffic with occasional flushes and head moves.
        vld = '0;
        acc = '0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) head = rob_idx_t'($urandom);
            for (int k = 0; k < 3; k++) begin
                if (!vld[k] || acc[k]) begin
                    vld[k] = ($urandom_range(0, 2) != 0);
                    dat[k] = rand_req();
                end
            end
            flush = ($urandom_range(0, 31) == 0);
            cycle();
        end
        flush = 1'b0;
        vld   = '0;
        repeat (6) cycle();

        // Async reset mid-stream, away from any clock edge.
        dat[0] = rand_req();
        dat[1] = rand_req();
        vld = 3'b011;
        cycle();
        vld = '0;
        cycle();
        chk("t7_pre_valid", wb_valid_o, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        chk("t7_async_valid", wb_valid_o, 1'b0);
        chk("t7_async_cnt", contention_cnt_o, 32'd0);
        check_outputs();
        #1;
        rstn = 1'b1;
        repeat (3) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
